// File: rtl/fa_response_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : fa_response_checker_if
//  Purpose  : Bundles the sweep-control handshake, the full-adder drive/response
//             lines and the result status of fa_response_checker.
//  Signals  : start            sweep request pulse (environment -> checker)
//             a, b, c          full-adder stimulus, {a,b,c} = current code
//             f1, f2           full-adder sum / carry response
//             busy, done, pass sweep status
//             err_count        mismatching codes in the current/last sweep
//             fail_valid       a mismatch has been seen in this sweep
//             first_fail_code  {a,b,c} of the first mismatch
//  Modports : master = environment side, slave = checker side
//  Revision : 1.0  initial release
// ============================================================================
interface fa_response_checker_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             a;
  logic             b;
  logic             c;
  logic             f1;
  logic             f2;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [2:0]       first_fail_code;

  modport master (
    output start, f1, f2,
    input  a, b, c, busy, done, pass, err_count, fail_valid, first_fail_code
  );

  modport slave (
    input  start, f1, f2,
    output a, b, c, busy, done, pass, err_count, fail_valid, first_fail_code
  );
endinterface
`default_nettype wire

// File: rtl/fa_response_checker.sv
`default_nettype none
// ============================================================================
//  Module   : fa_response_checker
//  Purpose  : Sweeps all eight input codes of a 1-bit full adder, holds each
//             code for SETTLE cycles, samples sum (f1) and carry (f2) and
//             compares them with the golden values. Counts mismatching codes
//             (saturating) and records the first failing code.
//  Ports    : clk   rising-edge clock
//             rst   synchronous active-high reset
//             bus   fa_response_checker_if.slave (start, a/b/c, f1/f2, status)
//  Params   : SETTLE  hold cycles per code before sampling (1..15)
//             ERR_W   err_count width, saturates at 2^ERR_W-1
//  Revision : 1.0  initial release
// ============================================================================
module fa_response_checker #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fa_response_checker_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0]       WAIT_LOAD = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  logic [1:0]       state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [3:0]       wait_q, wait_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [2:0]       first_q, first_d;

  logic exp_s;
  logic exp_c;
  logic mismatch;

  // Golden full-adder response for the code currently on a/b/c.
  assign exp_s = code_q[2] ^ code_q[1] ^ code_q[0];
  assign exp_c = (code_q[2] & code_q[1]) | (code_q[2] & code_q[0]) | (code_q[1] & code_q[0]);

  // Case inequality so an undriven or unknown response counts as a failure.
  assign mismatch = (bus.f1 !== exp_s) || (bus.f2 !== exp_c);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      code_q       <= 3'd0;
      wait_q       <= 4'd0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_q      <= 3'd0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_q      <= first_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    wait_d       = wait_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_d      = first_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Only these states accept start, so a held or repeated start
        // during a sweep is naturally ignored.
        if (bus.start) begin
          state_d      = S_SETTLE;
          code_d       = 3'd0;
          wait_d       = WAIT_LOAD;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_d      = 3'd0;
        end
      end
      S_SETTLE: begin
        if (wait_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_d      = code_q;
          end
        end
        if (code_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          code_d  = code_q + 3'd1;
          wait_d  = WAIT_LOAD;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: stimulus comes straight from the code register so it is glitch-free.
  always_comb begin
    bus.a               = code_q[2];
    bus.b               = code_q[1];
    bus.c               = code_q[0];
    bus.busy            = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    bus.done            = (state_q == S_DONE);
    bus.pass            = (state_q == S_DONE) && (err_q == '0);
    bus.err_count       = err_q;
    bus.fail_valid      = fail_valid_q;
    bus.first_fail_code = first_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fa_response_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fa_response_checker
//  Purpose  : Self-checking bench for fa_response_checker. Three checker
//             instances (SETTLE=2/ERR_W=4, SETTLE=2/ERR_W=2, SETTLE=1/ERR_W=4)
//             each face a modelled full adder whose outputs can be corrupted
//             per code by fault masks, or delayed through a two-register pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fa_response_checker;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err;
    logic       fv;
    logic [2:0] first;
    logic [2:0] abc;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Fault masks: bit k set flips the sum (m1) / carry (m2) seen for code k.
  logic [7:0] m1 = 8'h00;
  logic [7:0] m2 = 8'h00;
  logic       lag_mode = 1'b0;

  fa_response_checker_if #(.ERR_W(4)) bus0 ();
  fa_response_checker_if #(.ERR_W(2)) bus1 ();
  fa_response_checker_if #(.ERR_W(4)) bus2 ();

  fa_response_checker #(.SETTLE(2), .ERR_W(4)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  fa_response_checker #(.SETTLE(2), .ERR_W(2)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  fa_response_checker #(.SETTLE(1), .ERR_W(4)) u2 (.clk(clk), .rst(rst), .bus(bus2));

  // Golden full adder as arithmetic: returns {sum, carry}.
  function automatic logic [1:0] fa(input logic [2:0] k);
    int n;
    n = int'(k[2]) + int'(k[1]) + int'(k[0]);
    return {logic'(n % 2 == 1), logic'(n >= 2)};
  endfunction

  logic [2:0] abc0, abc1, abc2;
  logic [1:0] g0, g1, g2;
  logic [1:0] lag1 [3];
  logic [1:0] lag2 [3];

  assign abc0 = {bus0.a, bus0.b, bus0.c};
  assign abc1 = {bus1.a, bus1.b, bus1.c};
  assign abc2 = {bus2.a, bus2.b, bus2.c};
  assign g0 = fa(abc0);
  assign g1 = fa(abc1);
  assign g2 = fa(abc2);

  always @(posedge clk) begin
    lag1[0] <= g0;  lag1[1] <= g1;  lag1[2] <= g2;
    lag2[0] <= lag1[0];  lag2[1] <= lag1[1];  lag2[2] <= lag1[2];
  end

  assign bus0.f1 = lag_mode ? lag2[0][1] : (g0[1] ^ m1[abc0]);
  assign bus0.f2 = lag_mode ? lag2[0][0] : (g0[0] ^ m2[abc0]);
  assign bus1.f1 = lag_mode ? lag2[1][1] : (g1[1] ^ m1[abc1]);
  assign bus1.f2 = lag_mode ? lag2[1][0] : (g1[0] ^ m2[abc1]);
  assign bus2.f1 = lag_mode ? lag2[2][1] : (g2[1] ^ m1[abc2]);
  assign bus2.f2 = lag_mode ? lag2[2][0] : (g2[0] ^ m2[abc2]);

  st_t st0, st1, st2;
  assign st0 = {bus0.busy, bus0.done, bus0.pass, bus0.err_count, bus0.fail_valid,
                bus0.first_fail_code, abc0};
  assign st1 = {bus1.busy, bus1.done, bus1.pass, 4'(bus1.err_count), bus1.fail_valid,
                bus1.first_fail_code, abc1};
  assign st2 = {bus2.busy, bus2.done, bus2.pass, bus2.err_count, bus2.fail_valid,
                bus2.first_fail_code, abc2};

  function automatic st_t get(input int u);
    if (u == 1) return st1;
    if (u == 2) return st2;
    return st0;
  endfunction

  function automatic int settle_of(input int u);
    return (u == 2) ? 1 : 2;
  endfunction

  function automatic int errw_of(input int u);
    return (u == 1) ? 2 : 4;
  endfunction

  task automatic set_start(input int u, input logic v);
    case (u)
      1:       bus1.start = v;
      2:       bus2.start = v;
      default: bus0.start = v;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model. A masked DUT is wrong exactly on the masked codes. The
  // lagging DUT answers two cycles after its inputs change, so with fewer
  // than two hold cycles it still shows the previous code's answer.
  function automatic void predict(input int settle, input int errw, input logic lag,
                                  input logic [7:0] mm1, input logic [7:0] mm2,
                                  output int err, output logic fv, output int first);
    int prev;
    prev  = 0;
    err   = 0;
    fv    = 1'b0;
    first = 0;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] gold;
      logic [1:0] seen;
      gold = fa(3'(k));
      if (lag) seen = (settle >= 2) ? gold : fa(3'(prev));
      else     seen = gold ^ {mm1[k], mm2[k]};
      if (seen != gold) begin
        if (!fv) begin
          fv    = 1'b1;
          first = k;
        end
        err++;
      end
      prev = k;
    end
    if (err > (1 << errw) - 1) err = (1 << errw) - 1;
  endfunction

  // Pulses start (held for 'hold' cycles, plus extra pulses after cycles x1/x2),
  // then waits for done. lat = cycles from the accepting edge to done;
  // bad = cycles where a/b/c or busy deviated from the expected sweep.
  task automatic run_sweep(input int u, input int x1, input int x2, input int hold,
                           output int lat, output int bad);
    int   per;
    st_t  s;
    per = settle_of(u) + 1;
    lat = -1;
    bad = 0;
    set_start(u, 1'b1);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      set_start(u, ((n + 1) < hold) || (n == x1) || (n == x2));
      s = get(u);
      if (s.done) begin
        lat = n;
        break;
      end
      if ((s.abc != 3'(n / per)) || !s.busy) bad++;
    end
    set_start(u, 1'b0);
  endtask

  task automatic check_result(input string tag, input int u, input int lat, input int bad,
                              output int e);
    logic v;
    int   f;
    st_t  s;
    predict(settle_of(u), errw_of(u), lag_mode, m1, m2, e, v, f);
    s = get(u);
    check({tag, "_lat"},   lat, 8 * (settle_of(u) + 1));
    check({tag, "_seq"},   bad, 0);
    check({tag, "_done"},  s.done, 1);
    check({tag, "_busy"},  s.busy, 0);
    check({tag, "_abc"},   s.abc, 7);
    check({tag, "_err"},   s.err, e);
    check({tag, "_fv"},    s.fv, v);
    check({tag, "_first"}, s.first, f);
    check({tag, "_pass"},  s.pass, (e == 0));
  endtask

  task automatic check_reset(input int u, input string tag);
    st_t s;
    s = get(u);
    check({tag, "_busy"},  s.busy, 0);
    check({tag, "_done"},  s.done, 0);
    check({tag, "_pass"},  s.pass, 0);
    check({tag, "_err"},   s.err, 0);
    check({tag, "_fv"},    s.fv, 0);
    check({tag, "_first"}, s.first, 0);
    check({tag, "_abc"},   s.abc, 0);
  endtask

  initial begin
    int   lat, bad, e;
    st_t  s;

    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_reset(0, "rst_u0");
    check_reset(1, "rst_u1");
    check_reset(2, "rst_u2");

    // T1: ideal adder
    m1 = 8'h00; m2 = 8'h00;
    run_sweep(0, -1, -1, 1, lat, bad);
    check_result("t1", 0, lat, bad, e);

    // T2: carry stuck at 0 -> wrong wherever the carry should be 1
    for (int k = 0; k < 8; k++) begin
      logic [1:0] g;
      g = fa(3'(k));
      m2[k] = g[0];
    end
    run_sweep(0, -1, -1, 1, lat, bad);
    check_result("t2", 0, lat, bad, e);
    s = get(0);
    check("t2_err_const", s.err, 4);
    check("t2_first_const", s.first, 3);

    // T3: sum inverted, full and narrow counters
    m1 = 8'hff; m2 = 8'h00;
    run_sweep(0, -1, -1, 1, lat, bad);
    check_result("t3", 0, lat, bad, e);
    s = get(0);
    check("t3_err_const", s.err, 8);
    run_sweep(1, -1, -1, 1, lat, bad);
    check_result("t3w2", 1, lat, bad, e);
    s = get(1);
    check("t3w2_sat_const", s.err, 3);

    // T5: starts during the sweep are ignored
    m1 = 8'h00;
    run_sweep(0, 5, 12, 1, lat, bad);
    check_result("t5", 0, lat, bad, e);

    // Held start, plus a start coinciding with the final SAMPLE
    m1 = 8'h24;
    run_sweep(0, 23, -1, 3, lat, bad);
    check_result("t5b", 0, lat, bad, e);
    @(negedge clk);
    s = get(0);
    check("t5b_done_hold", s.done, 1);
    check("t5b_busy_hold", s.busy, 0);

    // Start in DONE clears results and begins a new sweep
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    s = get(0);
    check("t5c_done", s.done, 0);
    check("t5c_busy", s.busy, 1);
    check("t5c_err", s.err, 0);
    check("t5c_fv", s.fv, 0);
    check("t5c_first", s.first, 0);
    check("t5c_abc", s.abc, 0);

    // T4: reset mid-sweep (the restarted sweep above is aborted too)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m1 = 8'hff;
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (10) @(negedge clk);
    s = get(0);
    check("t4_pre_err", s.err, 3);
    rst = 1'b1;
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    check_reset(0, "t4_rst");
    rst = 1'b0;
    m1 = 8'h00;
    @(negedge clk);
    run_sweep(0, -1, -1, 1, lat, bad);
    check_result("t4_new", 0, lat, bad, e);

    // T6: adder answering late; fresh SETTLE=1 instance sits at code 0
    lag_mode = 1'b1;
    run_sweep(2, -1, -1, 1, lat, bad);
    check_result("t6_s1", 2, lat, bad, e);
    check("t6_s1_mis", (e > 0), 1);
    run_sweep(0, -1, -1, 1, lat, bad);
    check_result("t6_s2", 0, lat, bad, e);
    check("t6_s2_pass_const", e, 0);
    lag_mode = 1'b0;

    // Randomized fault masks, instances and stray starts
    for (int it = 0; it < 10; it++) begin
      int u, per, x;
      u   = int'($urandom_range(0, 2));
      per = settle_of(u) + 1;
      m1  = 8'($urandom);
      m2  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        m1 = 8'h00;
        m2 = 8'h00;
      end
      x = int'($urandom_range(1, 8 * per - 1));
      run_sweep(u, x, -1, int'($urandom_range(1, 3)), lat, bad);
      check_result($sformatf("rnd%0d_u%0d", it, u), u, lat, bad, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
